// File: rtl/snake_pkg.sv
// Shared definitions for the snake input-conditioning stage:
// heading encoding, turn deltas and the turn-latch state type.
package snake_pkg;

    // 2-bit heading, arithmetic is naturally modulo 4
    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    // Quarter-turn deltas added to the heading (left = -1 mod 4)
    localparam dir_t TURN_CW  = 2'd1;
    localparam dir_t TURN_CCW = 2'd3;

    // Turn latch: IDLE waits for a press, PENDING holds one turn until the next step
    typedef enum logic {
        LATCH_IDLE    = 1'b0,
        LATCH_PENDING = 1'b1
    } latch_state_t;

    // Rotate a heading by a quarter-turn delta; wraps 3+1 -> 0 and 0-1 -> 3
    function automatic dir_t apply_turn(input dir_t cur, input dir_t delta);
        return cur + delta;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button conditioning: 2-flop synchroniser, debounce counter,
// stable level register and a one-cycle press pulse on stable 1->0.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button level into the clock domain
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the stable one for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered press pulse on the stable released->pressed transition; release is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: debounced turn buttons, one-turn-per-step latch
// and the game step pulse generator.
// Optional feature: define SNAKE_TURN_LEFT_EN to add the turn_left_n button.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   TICK_DIV        = 10_000_000,
    parameter dir_t INIT_DIR        = DIR_LEFT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       turn_right_n,
`ifdef SNAKE_TURN_LEFT_EN
    input  logic       turn_left_n,
`endif
    output logic [1:0] dir,
    output logic       step_tick,
    output logic       turn_pending
);

    localparam int               TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_step_cnt;
    logic              r_step_tick;

    latch_state_t      r_state;
    latch_state_t      w_state_next;
    dir_t              r_turn;
    dir_t              w_turn_next;
    dir_t              r_dir;
    dir_t              w_dir_next;

    logic              w_right_press;
    logic              w_press_valid;
    dir_t              w_press_delta;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_right_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (turn_right_n),
        .o_press (w_right_press)
    );

`ifdef SNAKE_TURN_LEFT_EN
    logic w_left_press;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_left_btn (
        .clk     (clk),
        .reset   (reset),
        .i_btn_n (turn_left_n),
        .o_press (w_left_press)
    );

    // Opposite presses in the same cycle cancel each other
    assign w_press_valid = w_right_press ^ w_left_press;
    assign w_press_delta = w_right_press ? TURN_CW : TURN_CCW;
`else
    assign w_press_valid = w_right_press;
    assign w_press_delta = TURN_CW;
`endif

    // Game pacing: count 0..TICK_DIV-1 while running, register the terminal-count compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_cnt  <= '0;
            r_step_tick <= 1'b0;
        end else if (!run) begin
            r_step_cnt  <= '0;
            r_step_tick <= 1'b0;
        end else begin
            r_step_tick <= (r_step_cnt == TICK_LAST);
            r_step_cnt  <= (r_step_cnt == TICK_LAST) ? '0 : r_step_cnt + TICK_W'(1);
        end
    end

    // Turn-latch and heading registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LATCH_IDLE;
            r_turn  <= TURN_CW;
            r_dir   <= INIT_DIR;
        end else begin
            r_state <= w_state_next;
            r_turn  <= w_turn_next;
            r_dir   <= w_dir_next;
        end
    end

    // Next-state: latch one press, apply it at the step; a press on the step itself applies at once
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        w_turn_next  = r_turn;
        w_dir_next   = r_dir;
        case (r_state)
            LATCH_IDLE: begin
                if (w_press_valid) begin
                    if (r_step_tick) begin
                        w_dir_next = apply_turn(r_dir, w_press_delta);
                    end else begin
                        w_state_next = LATCH_PENDING;
                        w_turn_next  = w_press_delta;
                    end
                end
            end
            LATCH_PENDING: begin
                if (r_step_tick) begin
                    w_dir_next   = apply_turn(r_dir, r_turn);
                    w_state_next = LATCH_IDLE;
                end
            end
            default: w_state_next = LATCH_IDLE;
        endcase
    end

    assign dir          = r_dir;
    assign step_tick    = r_step_tick;
    assign turn_pending = (r_state == LATCH_PENDING);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=8, INIT_DIR=3.
// Cycle numbers below count rising edges since the last reset release.
module tb_snake_dir_ctrl;

    logic       clk;
    logic       reset;
    logic       run;
    logic       turn_right_n;
`ifdef SNAKE_TURN_LEFT_EN
    logic       turn_left_n;
`endif
    logic [1:0] dir;
    logic       step_tick;
    logic       turn_pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .TICK_DIV        (8),
        .INIT_DIR        (2'd3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .turn_right_n (turn_right_n),
`ifdef SNAKE_TURN_LEFT_EN
        .turn_left_n  (turn_left_n),
`endif
        .dir          (dir),
        .step_tick    (step_tick),
        .turn_pending (turn_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        reset        = 1'b1;
        run          = 1'b1;
        turn_right_n = 1'b1;
`ifdef SNAKE_TURN_LEFT_EN
        turn_left_n  = 1'b1;
`endif
        #2;
        check("rst_dir",  32'(dir), 3);
        check("rst_tick", 32'(step_tick), 0);
        check("rst_pend", 32'(turn_pending), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // Stepping: first tick at cycle 8, then every 8
        for (int k = 1; k <= 24; k++) begin
            step();
            check("tick_rate", 32'(step_tick), 32'(k % 8 == 0));
        end
        check("idle_dir",  32'(dir), 3);
        check("idle_pend", 32'(turn_pending), 0);

        // Single press: first low sample at edge 27, event after 33, pending after 34
        run_to(26); turn_right_n = 1'b0;
        run_to(33); check("press_pend_early", 32'(turn_pending), 0);
        run_to(34); check("press_pend",       32'(turn_pending), 1);
                    check("press_dir_hold",   32'(dir), 3);
        run_to(36); turn_right_n = 1'b1;
        run_to(40); check("press_tick",       32'(step_tick), 1);
                    check("press_dir_pre",    32'(dir), 3);
                    check("press_pend_pre",   32'(turn_pending), 1);
        run_to(41); check("press_dir_wrap",   32'(dir), 0);
                    check("press_pend_clr",   32'(turn_pending), 0);

        // Bounce: toggle every 2 cycles for 20 cycles, never stable long enough
        run_to(48);
        for (int k = 0; k < 20; k++) begin
            turn_right_n = ((k / 2) % 2 == 1);
            step();
            check("bounce_pend", 32'(turn_pending), 0);
        end
        turn_right_n = 1'b1;
        run_to(73); check("bounce_dir", 32'(dir), 0);

        // Press event lands in the same cycle as the tick (after edge 80): applied directly
        turn_right_n = 1'b0;
        run_to(80); check("same_tick",     32'(step_tick), 1);
                    check("same_pend",     32'(turn_pending), 0);
        run_to(81); check("same_dir",      32'(dir), 1);
                    check("same_pend_aft", 32'(turn_pending), 0);
        run_to(82); turn_right_n = 1'b1;
                    check("same_pend_end", 32'(turn_pending), 0);

        // Pause for 30 cycles with two presses; only the first is latched
        run_to(88); check("pre_pause_tick", 32'(step_tick), 1);
        run = 1'b0;
        turn_right_n = 1'b0;
        for (int k = 89; k <= 118; k++) begin
            step();
            check("pause_tick", 32'(step_tick), 0);
            check("pause_dir",  32'(dir), 1);
            check("pause_pend", 32'(turn_pending), 32'(k >= 96));
            if (k == 96 || k == 112) turn_right_n = 1'b1;
            if (k == 102)            turn_right_n = 1'b0;
        end
        run = 1'b1;
        for (int k = 119; k <= 127; k++) begin
            step();
            check("resume_tick", 32'(step_tick), 32'(k == 126));
            check("resume_dir",  32'(dir), (k == 127) ? 2 : 1);
            check("resume_pend", 32'(turn_pending), 32'(k <= 126));
        end
        run_to(134); check("next_tick", 32'(step_tick), 1);
        run_to(135); check("one_turn_dir",  32'(dir), 2);
                     check("one_turn_pend", 32'(turn_pending), 0);

        // Asynchronous reset mid-cycle drops a pending turn
        run_to(136); turn_right_n = 1'b0;
        run_to(144); check("mid_pend", 32'(turn_pending), 1);
        run_to(146);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_dir",  32'(dir), 3);
        check("mid_rst_pend", 32'(turn_pending), 0);
        check("mid_rst_tick", 32'(step_tick), 0);
        turn_right_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("post_rst_tick", 32'(step_tick), 32'(k == 8));
        end

`ifdef SNAKE_TURN_LEFT_EN
        // Right to reach UP, then left wraps 0 -> 3, then simultaneous presses cancel
        run_to(10); turn_right_n = 1'b0;
        run_to(19); turn_right_n = 1'b1;
        run_to(25); check("lr_right_dir", 32'(dir), 0);
        run_to(26); turn_left_n = 1'b0;
        run_to(34); check("lr_left_pend", 32'(turn_pending), 1);
        run_to(35); turn_left_n = 1'b1;
        run_to(41); check("lr_left_dir",  32'(dir), 3);
        run_to(42); turn_right_n = 1'b0; turn_left_n = 1'b0;
        for (int k = 43; k <= 57; k++) begin
            step();
            check("lr_both_pend", 32'(turn_pending), 0);
            if (k == 52) begin
                turn_right_n = 1'b1;
                turn_left_n  = 1'b1;
            end
        end
        check("lr_both_dir", 32'(dir), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
